// File: rtl/acc_c_responder.sv
// Accelerator-side C-bus responder. Forwards Q-channel requests straight to
// the local datapath, remembers each issued {id, rd} in an in-order tag FIFO,
// and returns tagged datapath results on the P channel from a registered stage.
module acc_c_responder #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned AddrWidth = 5,
   parameter int unsigned IdWidth   = 5,
   parameter int unsigned Depth     = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   // Q channel (requests in)
   input  logic [AddrWidth-1:0] q_addr_i,
   input  logic [31:0]          q_data_op_i,
   input  logic [DataWidth-1:0] q_data_arga_i,
   input  logic [DataWidth-1:0] q_data_argb_i,
   input  logic [DataWidth-1:0] q_data_argc_i,
   input  logic [IdWidth-1:0]   q_id_i,
   input  logic                 q_valid_i,
   output logic                 q_ready_o,
   // P channel (responses out)
   output logic [DataWidth-1:0] p_data0_o,
   output logic [DataWidth-1:0] p_data1_o,
   output logic                 p_dual_writeback_o,
   output logic [IdWidth-1:0]   p_id_o,
   output logic [4:0]           p_rd_o,
   output logic                 p_error_o,
   output logic                 p_valid_o,
   input  logic                 p_ready_i,
   // Datapath request port
   output logic [31:0]          acc_req_op_o,
   output logic [DataWidth-1:0] acc_req_arga_o,
   output logic [DataWidth-1:0] acc_req_argb_o,
   output logic [DataWidth-1:0] acc_req_argc_o,
   output logic                 acc_req_valid_o,
   input  logic                 acc_req_ready_i,
   // Datapath result port
   input  logic [DataWidth-1:0] acc_rsp_data0_i,
   input  logic [DataWidth-1:0] acc_rsp_data1_i,
   input  logic                 acc_rsp_dual_i,
   input  logic                 acc_rsp_wb_i,
   input  logic                 acc_rsp_error_i,
   input  logic                 acc_rsp_valid_i,
   output logic                 acc_rsp_ready_o
);

   localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntWidth = $clog2(Depth + 1);

   typedef struct packed {
      logic [IdWidth-1:0] id;
      logic [4:0]         rd;
   } tag_t;

   tag_t                tag_mem [Depth];
   logic [PtrWidth-1:0] wr_ptr;
   logic [PtrWidth-1:0] rd_ptr;
   logic [CntWidth-1:0] count;
   logic                full;
   logic                empty;
   logic                push;
   logic                pop;
   logic                load;
   tag_t                head;

   // The address only routes the request through the interconnect.
   logic unused_addr;
   assign unused_addr = ^q_addr_i;

   function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
      return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + PtrWidth'(1);
   endfunction

   assign full  = (count == CntWidth'(Depth));
   assign empty = (count == '0);

   // Request path is pure wiring; a full tag FIFO blocks issue in both directions.
   assign acc_req_op_o    = q_data_op_i;
   assign acc_req_arga_o  = q_data_arga_i;
   assign acc_req_argb_o  = q_data_argb_i;
   assign acc_req_argc_o  = q_data_argc_i;
   assign acc_req_valid_o = q_valid_i & ~full;
   assign q_ready_o       = acc_req_ready_i & ~full;
   assign push            = q_valid_i & q_ready_o;

   // A result is only taken when a tag exists for it and the P stage can move.
   assign acc_rsp_ready_o = ~empty & (~p_valid_o | p_ready_i);
   assign pop             = acc_rsp_valid_i & acc_rsp_ready_o;
   assign load            = pop & (acc_rsp_wb_i | acc_rsp_error_i);
   assign head            = tag_mem[rd_ptr];

   // Tag storage: write the issuing request's id and destination register.
   // NOTE: the storage array has no reset; count alone says which entries are live,
   // so clearing it would only add reset fan-out.
   always_ff @(posedge clk_i) begin
      if (push) begin
         tag_mem[wr_ptr] <= '{id: q_id_i, rd: q_data_op_i[11:7]};
      end
   end

   // Tag FIFO pointers and occupancy.
   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CntWidth'(1);
            2'b01:   count <= count - CntWidth'(1);
            default: count <= count;
         endcase
      end
   end

   // P output register: load on a writeback/error result, hold under backpressure,
   // drop valid once the consumer has taken the beat and nothing replaces it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         p_data0_o          <= '0;
         p_data1_o          <= '0;
         p_dual_writeback_o <= 1'b0;
         p_id_o             <= '0;
         p_rd_o             <= '0;
         p_error_o          <= 1'b0;
         p_valid_o          <= 1'b0;
      end else if (load) begin
         p_data0_o          <= acc_rsp_data0_i;
         p_data1_o          <= acc_rsp_data1_i;
         p_dual_writeback_o <= acc_rsp_dual_i;
         p_id_o             <= head.id;
         p_rd_o             <= head.rd;
         p_error_o          <= acc_rsp_error_i;
         p_valid_o          <= 1'b1;
      end else if (pop || (p_valid_o && p_ready_i)) begin
         p_valid_o          <= 1'b0;
      end
   end

endmodule

// File: tb/tb_acc_c_responder.sv
// Self-checking bench for acc_c_responder: table-driven single operations plus
// hand-written fill/wrap, backpressure and mid-operation reset sequences. A
// negedge monitor compares every P beat against a scoreboard queue.
module tb_acc_c_responder;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int IW    = 5;
   localparam int DEPTH = 4;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [AW-1:0] q_addr_i;
   logic [31:0]   q_data_op_i;
   logic [DW-1:0] q_data_arga_i, q_data_argb_i, q_data_argc_i;
   logic [IW-1:0] q_id_i;
   logic          q_valid_i;
   logic          q_ready_o;
   logic [DW-1:0] p_data0_o, p_data1_o;
   logic          p_dual_writeback_o;
   logic [IW-1:0] p_id_o;
   logic [4:0]    p_rd_o;
   logic          p_error_o;
   logic          p_valid_o;
   logic          p_ready_i;
   logic [31:0]   acc_req_op_o;
   logic [DW-1:0] acc_req_arga_o, acc_req_argb_o, acc_req_argc_o;
   logic          acc_req_valid_o;
   logic          acc_req_ready_i;
   logic [DW-1:0] acc_rsp_data0_i, acc_rsp_data1_i;
   logic          acc_rsp_dual_i, acc_rsp_wb_i, acc_rsp_error_i;
   logic          acc_rsp_valid_i;
   logic          acc_rsp_ready_o;

   acc_c_responder #(
      .DataWidth(DW), .AddrWidth(AW), .IdWidth(IW), .Depth(DEPTH)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .q_addr_i(q_addr_i), .q_data_op_i(q_data_op_i),
      .q_data_arga_i(q_data_arga_i), .q_data_argb_i(q_data_argb_i),
      .q_data_argc_i(q_data_argc_i), .q_id_i(q_id_i),
      .q_valid_i(q_valid_i), .q_ready_o(q_ready_o),
      .p_data0_o(p_data0_o), .p_data1_o(p_data1_o),
      .p_dual_writeback_o(p_dual_writeback_o), .p_id_o(p_id_o),
      .p_rd_o(p_rd_o), .p_error_o(p_error_o),
      .p_valid_o(p_valid_o), .p_ready_i(p_ready_i),
      .acc_req_op_o(acc_req_op_o), .acc_req_arga_o(acc_req_arga_o),
      .acc_req_argb_o(acc_req_argb_o), .acc_req_argc_o(acc_req_argc_o),
      .acc_req_valid_o(acc_req_valid_o), .acc_req_ready_i(acc_req_ready_i),
      .acc_rsp_data0_i(acc_rsp_data0_i), .acc_rsp_data1_i(acc_rsp_data1_i),
      .acc_rsp_dual_i(acc_rsp_dual_i), .acc_rsp_wb_i(acc_rsp_wb_i),
      .acc_rsp_error_i(acc_rsp_error_i), .acc_rsp_valid_i(acc_rsp_valid_i),
      .acc_rsp_ready_o(acc_rsp_ready_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [4:0]    rd;
   } tag_t;

   typedef struct {
      logic [IW-1:0] id;
      logic [4:0]    rd;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic          dual;
      logic          err;
   } beat_t;

   typedef struct {
      logic [IW-1:0] id;
      logic [4:0]    rd;
      logic [DW-1:0] arga;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic          dual;
      logic          wb;
      logic          err;
      logic          exp_valid;
   } vec_t;

   int    n_cmp  = 0;
   int    n_fail = 0;
   tag_t  tags_q[$];
   beat_t exp_q[$];
   vec_t  vecs[5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Drive one request that must be accepted; checks forwarding to the datapath.
   task automatic issue(input logic [IW-1:0] id, input logic [4:0] rd, input logic [DW-1:0] arga);
      logic [31:0] op;
      op = {20'h5A5A5, rd, 7'h2B};
      q_valid_i       = 1'b1;
      q_id_i          = id;
      q_data_op_i     = op;
      q_data_arga_i   = arga;
      q_data_argb_i   = arga ^ 32'hFFFF_0000;
      q_data_argc_i   = arga + 32'd7;
      q_addr_i        = 5'($urandom);
      acc_req_ready_i = 1'b1;
      #1;
      check("q_ready", q_ready_o, 1);
      check("req_valid", acc_req_valid_o, 1);
      check("req_op", acc_req_op_o, op);
      check("req_arga", acc_req_arga_o, arga);
      check("req_argc", acc_req_argc_o, arga + 32'd7);
      @(posedge clk_i);
      #1;
      q_valid_i = 1'b0;
      tags_q.push_back('{id: id, rd: rd});
   endtask

   // Present one datapath result and wait (bounded) for it to be taken.
   task automatic respond(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                          input logic dual, input logic wb, input logic err);
      tag_t t;
      acc_rsp_data0_i = d0;
      acc_rsp_data1_i = d1;
      acc_rsp_dual_i  = dual;
      acc_rsp_wb_i    = wb;
      acc_rsp_error_i = err;
      acc_rsp_valid_i = 1'b1;
      #1;
      for (int i = 0; i < 50 && acc_rsp_ready_o !== 1'b1; i++) tick();
      check("rsp_ready", acc_rsp_ready_o, 1);
      @(posedge clk_i);
      #1;
      acc_rsp_valid_i = 1'b0;
      if (tags_q.size() > 0) begin
         t = tags_q.pop_front();
         if (wb || err) exp_q.push_back('{id: t.id, rd: t.rd, d0: d0, d1: d1, dual: dual, err: err});
      end
   endtask

   // Scoreboard: every completed P beat must match the oldest expected beat.
   always @(negedge clk_i) begin
      if (rst_i === 1'b0 && p_valid_o === 1'b1 && p_ready_i === 1'b1) begin
         beat_t b;
         check("beat_expected", 64'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            check("beat_id", p_id_o, b.id);
            check("beat_rd", p_rd_o, b.rd);
            check("beat_data0", p_data0_o, b.d0);
            check("beat_data1", p_data1_o, b.d1);
            check("beat_dual", p_dual_writeback_o, b.dual);
            check("beat_error", p_error_o, b.err);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tag_t t;
      vecs[0] = '{id: 5'd3,  rd: 5'd7,  arga: 32'h10,   d0: 32'h20,      d1: 32'h0,       dual: 1'b0, wb: 1'b1, err: 1'b0, exp_valid: 1'b1};
      vecs[1] = '{id: 5'd5,  rd: 5'd9,  arga: 32'h55,   d0: 32'h1234,    d1: 32'h0,       dual: 1'b0, wb: 1'b0, err: 1'b0, exp_valid: 1'b0};
      vecs[2] = '{id: 5'd6,  rd: 5'd2,  arga: 32'h66,   d0: 32'h0BAD,    d1: 32'h0,       dual: 1'b0, wb: 1'b0, err: 1'b1, exp_valid: 1'b1};
      vecs[3] = '{id: 5'd17, rd: 5'd31, arga: 32'hA5A5, d0: 32'hDEAD0000, d1: 32'h0000BEEF, dual: 1'b1, wb: 1'b1, err: 1'b0, exp_valid: 1'b1};
      vecs[4] = '{id: 5'd31, rd: 5'd0,  arga: 32'hFFFF, d0: 32'h7,       d1: 32'h8,       dual: 1'b0, wb: 1'b1, err: 1'b1, exp_valid: 1'b1};

      // Reset with a pending request: ready follows the datapath, no P beat.
      rst_i = 1'b1; q_valid_i = 1'b1; acc_req_ready_i = 1'b1; p_ready_i = 1'b1;
      q_addr_i = '0; q_data_op_i = '0; q_id_i = '0;
      q_data_arga_i = '0; q_data_argb_i = '0; q_data_argc_i = '0;
      acc_rsp_data0_i = '0; acc_rsp_data1_i = '0; acc_rsp_dual_i = 1'b0;
      acc_rsp_wb_i = 1'b0; acc_rsp_error_i = 1'b0; acc_rsp_valid_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_q_ready_hi", q_ready_o, 1);
      check("rst_p_valid", p_valid_o, 0);
      check("rst_p_id", p_id_o, 0);
      acc_req_ready_i = 1'b0;
      #1;
      check("rst_q_ready_lo", q_ready_o, 0);
      check("rst_req_valid", acc_req_valid_o, 1);
      q_valid_i = 1'b0; acc_req_ready_i = 1'b1;
      rst_i = 1'b0;
      tick();
      // A result with no outstanding tag is left unacknowledged.
      acc_rsp_valid_i = 1'b1; acc_rsp_wb_i = 1'b1;
      #1;
      check("empty_rsp_ready", acc_rsp_ready_o, 0);
      tick();
      check("empty_rsp_ready_held", acc_rsp_ready_o, 0);
      check("empty_p_valid", p_valid_o, 0);
      acc_rsp_valid_i = 1'b0; acc_rsp_wb_i = 1'b0;

      // Table of single operations: issue, return result, check the P stage.
      for (int i = 0; i < 5; i++) begin
         issue(vecs[i].id, vecs[i].rd, vecs[i].arga);
         respond(vecs[i].d0, vecs[i].d1, vecs[i].dual, vecs[i].wb, vecs[i].err);
         check("tbl_p_valid", p_valid_o, vecs[i].exp_valid);
         if (vecs[i].exp_valid) begin
            check("tbl_p_id", p_id_o, vecs[i].id);
            check("tbl_p_rd", p_rd_o, vecs[i].rd);
            check("tbl_p_data0", p_data0_o, vecs[i].d0);
            check("tbl_p_error", p_error_o, vecs[i].err);
         end
         tick();
      end

      // Fill the tag FIFO with results stalled; the next request is blocked.
      for (int i = 0; i < DEPTH; i++) issue(5'(i), 5'(10 + i), 32'(i));
      q_valid_i = 1'b1; q_id_i = 5'd4; q_data_op_i = 32'h0000_0A00;
      #1;
      check("full_q_ready", q_ready_o, 0);
      check("full_req_valid", acc_req_valid_o, 0);
      // A pop in the same cycle must not let the blocked request in.
      acc_rsp_data0_i = 32'h100; acc_rsp_data1_i = '0; acc_rsp_dual_i = 1'b0;
      acc_rsp_wb_i = 1'b1; acc_rsp_error_i = 1'b0; acc_rsp_valid_i = 1'b1;
      #1;
      check("full_pop_rsp_ready", acc_rsp_ready_o, 1);
      check("full_pop_q_ready", q_ready_o, 0);
      @(posedge clk_i);
      #1;
      acc_rsp_valid_i = 1'b0; q_valid_i = 1'b0;
      t = tags_q.pop_front();
      exp_q.push_back('{id: t.id, rd: t.rd, d0: 32'h100, d1: '0, dual: 1'b0, err: 1'b0});
      #1;
      check("after_pop_q_ready", q_ready_o, 1);
      for (int i = 1; i < DEPTH; i++) respond(32'h100 + 32'(i), 32'(i), 1'b0, 1'b1, 1'b0);
      // Second round exercises pointer wrap.
      for (int i = 0; i < DEPTH; i++) issue(5'(8 + i), 5'(20 + i), 32'h200 + 32'(i));
      for (int i = 0; i < DEPTH; i++) respond(32'h300 + 32'(i), 32'h400 + 32'(i), 1'(i), 1'b1, 1'b0);
      tick();

      // Backpressure: P held stable, result port stalled, then no-bubble handoff.
      issue(5'd20, 5'd4, 32'h1);
      issue(5'd21, 5'd5, 32'h2);
      p_ready_i = 1'b0;
      respond(32'hAAA, 32'h1, 1'b0, 1'b1, 1'b0);
      acc_rsp_data0_i = 32'hBBB; acc_rsp_data1_i = 32'h2; acc_rsp_dual_i = 1'b0;
      acc_rsp_wb_i = 1'b1; acc_rsp_error_i = 1'b0; acc_rsp_valid_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("bp_p_valid", p_valid_o, 1);
         check("bp_p_id", p_id_o, 5'd20);
         check("bp_p_rd", p_rd_o, 5'd4);
         check("bp_p_data0", p_data0_o, 32'hAAA);
         check("bp_rsp_ready", acc_rsp_ready_o, 0);
         tick();
      end
      p_ready_i = 1'b1;
      #1;
      check("bp_release_rsp_ready", acc_rsp_ready_o, 1);
      @(posedge clk_i);
      #1;
      acc_rsp_valid_i = 1'b0;
      t = tags_q.pop_front();
      exp_q.push_back('{id: t.id, rd: t.rd, d0: 32'hBBB, d1: 32'h2, dual: 1'b0, err: 1'b0});
      check("b2b_p_valid", p_valid_o, 1);
      check("b2b_p_id", p_id_o, 5'd21);
      tick();
      tick();

      // Reset with two tags outstanding and a held response.
      p_ready_i = 1'b0;
      issue(5'd12, 5'd1, 32'h12);
      issue(5'd13, 5'd2, 32'h13);
      issue(5'd14, 5'd3, 32'h14);
      respond(32'hCCC, 32'h0, 1'b0, 1'b1, 1'b0);
      check("pre_rst_p_valid", p_valid_o, 1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      tags_q.delete();
      exp_q.delete();
      p_ready_i = 1'b1;
      #1;
      check("mid_rst_p_valid", p_valid_o, 0);
      check("mid_rst_rsp_ready", acc_rsp_ready_o, 0);
      check("mid_rst_p_id", p_id_o, 0);
      check("mid_rst_p_data0", p_data0_o, 0);
      // Full capacity must be available again after reset.
      for (int i = 0; i < DEPTH; i++) issue(5'(24 + i), 5'(i + 1), 32'h500 + 32'(i));
      q_valid_i = 1'b1;
      #1;
      check("post_rst_full", q_ready_o, 0);
      q_valid_i = 1'b0;
      for (int i = 0; i < DEPTH; i++) respond(32'h600 + 32'(i), 32'h0, 1'b0, 1'b1, 1'b0);

      repeat (5) tick();
      check("exp_queue_drained", 64'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
